// File: rtl/ws2812b_pkg.sv
// Shared types and helpers for the WS2812B frame path: pixel type, sequencer
// states and the RAM-order to wire-order pixel shuffle.
package ws2812b_pkg;

    typedef logic [23:0] pixel_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_SEND,
        S_DRAIN,
        S_LATCH,
        S_FINISH
    } seq_state_e;

    // 300 us of line-low latch time at a 50 MHz system clock.
    localparam int unsigned DEFAULT_RESET_CYCLES = 15000;

    // RAM stores {R,G,B}; the LEDs expect {G,R,B} on the wire.
    function automatic pixel_t grb_reorder(input pixel_t p);
        return {p[15:8], p[23:16], p[7:0]};
    endfunction

endpackage

// File: rtl/ws2812b_latch_timer.sv
// Loadable down-counter that times the line-low latch period. It loads
// RESET_CYCLES-1, so expired_o is raised after exactly RESET_CYCLES run cycles.
module ws2812b_latch_timer #(
    parameter int unsigned RESET_CYCLES = ws2812b_pkg::DEFAULT_RESET_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic run_i,
    output logic expired_o
);
    localparam int CW = $clog2(RESET_CYCLES + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(RESET_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (run_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/ws2812b_frame_sequencer.sv
// Frame controller: reads pixels from the I2C-written RAM, hands them to the
// WS2812B serializer in wire order, then holds the latch time and pulses done.
module ws2812b_frame_sequencer
    import ws2812b_pkg::*;
#(
    parameter int unsigned NUM_LEDS     = 8,
    parameter int unsigned RESET_CYCLES = DEFAULT_RESET_CYCLES,
    parameter bit          GRB_SWAP     = 1'b1,
    localparam int         LED_AW       = $clog2(NUM_LEDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [LED_AW:0]   num_leds_i,
    output logic              rd_en_o,
    output logic [LED_AW-1:0] rd_addr_o,
    input  pixel_t            rd_data_i,
    output pixel_t            px_data_o,
    output logic              px_valid_o,
    input  logic              px_ready_i,
    input  logic              ser_idle_i,
    output logic              busy_o,
    output logic              done_o
);
    localparam logic [LED_AW:0] MAX_LEDS = (LED_AW+1)'(NUM_LEDS);

    seq_state_e        state_q, state_d;
    logic [LED_AW-1:0] idx_q, idx_d;
    logic [LED_AW:0]   n_q, n_d;
    logic              pend_q, pend_d;
    pixel_t            px_data_q, px_data_d;
    logic              px_valid_q, px_valid_d;

    logic            tmr_load, tmr_run, tmr_expired;
    logic [LED_AW:0] n_clamped;
    logic            last_px;

    assign n_clamped = (num_leds_i > MAX_LEDS) ? MAX_LEDS : num_leds_i;
    assign last_px   = (({1'b0, idx_q} + 1'b1) == n_q);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        n_d        = n_q;
        pend_d     = pend_q;
        px_data_d  = px_data_q;
        px_valid_d = px_valid_q;
        tmr_load   = 1'b0;
        tmr_run    = 1'b0;

        // A start that arrives mid-frame (FINISH included) is queued one deep.
        if (start_i && (state_q != S_IDLE)) begin
            pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i || pend_q) begin
                    n_d     = n_clamped;
                    idx_d   = '0;
                    pend_d  = 1'b0;
                    state_d = (n_clamped == '0) ? S_FINISH : S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                px_data_d  = GRB_SWAP ? grb_reorder(rd_data_i) : rd_data_i;
                px_valid_d = 1'b1;
                state_d    = S_SEND;
            end
            S_SEND: begin
                if (px_ready_i) begin
                    px_valid_d = 1'b0;
                    if (last_px) begin
                        state_d = S_DRAIN;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DRAIN: begin
                if (ser_idle_i) begin
                    tmr_load = 1'b1;
                    state_d  = S_LATCH;
                end
            end
            S_LATCH: begin
                tmr_run = 1'b1;
                if (tmr_expired) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            n_q        <= '0;
            pend_q     <= 1'b0;
            px_data_q  <= '0;
            px_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            n_q        <= n_d;
            pend_q     <= pend_d;
            px_data_q  <= px_data_d;
            px_valid_q <= px_valid_d;
        end
    end

    ws2812b_latch_timer #(
        .RESET_CYCLES(RESET_CYCLES)
    ) u_latch_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (tmr_load),
        .run_i    (tmr_run),
        .expired_o(tmr_expired)
    );

    assign rd_en_o    = (state_q == S_FETCH);
    assign rd_addr_o  = idx_q;
    assign px_data_o  = px_data_q;
    assign px_valid_o = px_valid_q;
    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_FINISH);

endmodule

// File: tb/tb_ws2812b_frame_sequencer.sv
// Bench for the frame sequencer: a frame-level model predicts reads, pixels,
// busy and done timing, checked every cycle, plus directed literal scenarios.
module tb_ws2812b_frame_sequencer;
    localparam int NL = 8;
    localparam int RC = 10;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic [AW:0]   num_leds_i = '0;
    logic          rd_en_o;
    logic [AW-1:0] rd_addr_o;
    logic [23:0]   rd_data_i = '0;
    logic [23:0]   px_data_o;
    logic          px_valid_o;
    logic          px_ready_i = 1'b1;
    logic          ser_idle_i = 1'b1;
    logic          busy_o;
    logic          done_o;

    ws2812b_frame_sequencer #(.NUM_LEDS(NL), .RESET_CYCLES(RC), .GRB_SWAP(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .num_leds_i(num_leds_i),
        .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
        .px_data_o(px_data_o), .px_valid_o(px_valid_o), .px_ready_i(px_ready_i),
        .ser_idle_i(ser_idle_i), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    logic [23:0] ram [NL];
    always @(posedge clk) if (rd_en_o) rd_data_i <= ram[rd_addr_o];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] wire_order(input logic [23:0] p);
        logic [7:0] r, g, b;
        r = p[23:16]; g = p[15:8]; b = p[7:0];
        return {g, r, b};
    endfunction

    // Frame-level model state
    bit          m_busy = 0, m_pend = 0, wait_idle = 0, hold_prev = 0;
    int          m_n = 0, exp_addr = 0;
    int          done_due = -1, rd_due = -1, vld_due = -1;
    int          last_hs = -1, last_done = -1, first_rd = -1, first_vld = -1, first_addr = -1;
    int          hs_total = 0, rd_total = 0, done_cnt = 0;
    logic [23:0] prev_data;
    logic [23:0] exp_q[$];
    logic [23:0] hs_log[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_pend = 0; wait_idle = 0; hold_prev = 0;
            done_due = -1; rd_due = -1; vld_due = -1;
            exp_q.delete();
        end else begin
            chk("busy", {31'd0, busy_o}, {31'd0, m_busy});
            chk("done", {31'd0, done_o}, {31'd0, cyc == done_due});
            if (wait_idle && ser_idle_i) begin
                done_due  = cyc + RC + 1;
                wait_idle = 0;
            end
            if (hold_prev) begin
                chk("hold_valid", {31'd0, px_valid_o}, 32'd1);
                chk("hold_data", {8'd0, px_data_o}, {8'd0, prev_data});
            end
            if (cyc == rd_due)  chk("rd_latency", {31'd0, rd_en_o}, 32'd1);
            if (cyc == vld_due) chk("vld_latency", {31'd0, px_valid_o}, 32'd1);
            if (rd_en_o) begin
                rd_total++;
                if (first_rd < 0) begin first_rd = cyc; first_addr = int'(rd_addr_o); end
                chk("rd_addr", {29'd0, rd_addr_o}, exp_addr);
                chk("rd_in_frame", {31'd0, exp_addr < m_n}, 32'd1);
                chk("rd_while_valid", {31'd0, px_valid_o}, 32'd0);
                exp_addr++;
            end
            if (px_valid_o && first_vld < 0) first_vld = cyc;
            if (px_valid_o && px_ready_i) begin
                hs_total++;
                hs_log.push_back(px_data_o);
                last_hs = cyc;
                chk("px_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    chk("px_data", {8'd0, px_data_o}, {8'd0, exp_q.pop_front()});
                    if (exp_q.size() == 0) wait_idle = 1;
                end
            end
            hold_prev = px_valid_o && !px_ready_i;
            prev_data = px_data_o;
            if (done_o) begin
                done_cnt++;
                last_done = cyc;
                chk("frame_reads", exp_addr, m_n);
                chk("frame_pixels", exp_q.size(), 32'd0);
            end
            if (!m_busy) begin
                if (start_i || m_pend) begin
                    m_n = (int'(num_leds_i) > NL) ? NL : int'(num_leds_i);
                    exp_q.delete();
                    for (int i = 0; i < m_n; i++) exp_q.push_back(wire_order(ram[i]));
                    exp_addr = 0;
                    m_pend   = 0;
                    m_busy   = 1;
                    if (m_n == 0) done_due = cyc + 1;
                    else begin rd_due = cyc + 1; vld_due = cyc + 3; end
                end
            end else begin
                if (start_i) m_pend = 1;
                if (cyc == done_due) m_busy = 0;
            end
        end
    end

    // Serializer stand-in: ready/idle behaviour selected by the scenario
    int rdy_mode = 0;
    bit ser_mode = 0;
    int vcnt = 0;
    initial forever begin
        @(posedge clk); #1;
        if (px_valid_o) vcnt++; else vcnt = 0;
        case (rdy_mode)
            1:       px_ready_i = ($urandom_range(0, 9) < 7);
            2:       px_ready_i = (vcnt > 50);
            default: px_ready_i = 1'b1;
        endcase
        if (ser_mode) ser_idle_i = ($urandom_range(0, 3) != 0);
    end

    task automatic pulse_start(input int n, output int s);
        @(posedge clk); #1;
        num_leds_i = n[AW:0];
        start_i    = 1'b1;
        s          = cyc;
        @(posedge clk); #1;
        start_i    = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string nm);
        int i;
        i = 0;
        while (done_cnt < target && i < budget) begin @(posedge clk); i++; end
        chk(nm, {31'd0, done_cnt >= target}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int s, base, bhs, brd, ex, i;
        for (int k = 0; k < NL; k++) ram[k] = '0;
        #3;
        chk("rst_rd_en", {31'd0, rd_en_o}, 32'd0);
        chk("rst_rd_addr", {29'd0, rd_addr_o}, 32'd0);
        chk("rst_px_data", {8'd0, px_data_o}, 32'd0);
        chk("rst_px_valid", {31'd0, px_valid_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic 3-pixel frame, ready always high
        ram[0] = 24'hFF0000; ram[1] = 24'h00FF00; ram[2] = 24'h0000FF;
        hs_log.delete(); first_rd = -1; first_vld = -1;
        base = done_cnt;
        pulse_start(3, s);
        wait_done(base + 1, 200, "t1_timeout");
        chk("t1_hs_count", hs_log.size(), 32'd3);
        if (hs_log.size() >= 3) begin
            chk("t1_px0", {8'd0, hs_log[0]}, 32'h00FF00);
            chk("t1_px1", {8'd0, hs_log[1]}, 32'hFF0000);
            chk("t1_px2", {8'd0, hs_log[2]}, 32'h0000FF);
        end
        chk("t1_rd_lat", first_rd - s, 32'd1);
        chk("t1_vld_lat", first_vld - s, 32'd3);
        chk("t1_done_lat", last_done - last_hs, RC + 2);

        // Backpressure: ready held low ~50 cycles per pixel
        rdy_mode = 2; bhs = hs_total; brd = rd_total; base = done_cnt;
        pulse_start(3, s);
        wait_done(base + 1, 600, "t2_timeout");
        chk("t2_handshakes", hs_total - bhs, 32'd3);
        chk("t2_reads", rd_total - brd, 32'd3);
        rdy_mode = 0;

        // Zero LEDs: no reads, done right after the start is taken
        bhs = hs_total; brd = rd_total; base = done_cnt; first_vld = -1;
        pulse_start(0, s);
        wait_done(base + 1, 50, "t3a_timeout");
        chk("t3a_reads", rd_total - brd, 32'd0);
        chk("t3a_valid", first_vld, 32'hFFFF_FFFF);
        chk("t3a_done_lat", last_done - s, 32'd1);

        // Over-range count clamps to NUM_LEDS
        for (int k = 0; k < NL; k++) ram[k] = 24'($urandom);
        bhs = hs_total; brd = rd_total; base = done_cnt; first_rd = -1;
        pulse_start(15, s);
        wait_done(base + 1, 300, "t3b_timeout");
        chk("t3b_reads", rd_total - brd, 32'd8);
        chk("t3b_handshakes", hs_total - bhs, 32'd8);
        chk("t3b_first_addr", first_addr, 32'd0);

        // Three starts while busy merge into one extra frame
        base = done_cnt;
        pulse_start(3, s);
        for (int k = 0; k < 3; k++) pulse_start(3, s);
        wait_done(base + 2, 300, "t4_timeout");
        repeat (40) @(posedge clk);
        chk("t4_done_count", done_cnt - base, 32'd2);

        // Serializer still busy after the last handshake
        ser_idle_i = 1'b0; bhs = hs_total; base = done_cnt;
        pulse_start(3, s);
        i = 0;
        while (hs_total < bhs + 3 && i < 200) begin @(posedge clk); i++; end
        chk("t5_hs_timeout", {31'd0, hs_total >= bhs + 3}, 32'd1);
        repeat (40) @(posedge clk);
        #1 ser_idle_i = 1'b1;
        s = cyc;
        wait_done(base + 1, 100, "t5_timeout");
        chk("t5_latch_after_idle", last_done - s, RC + 1);
        chk("t5_no_early_latch", {31'd0, (last_done - last_hs) > 40 + RC}, 32'd1);

        // Async reset while pixel 2 is waiting in SEND
        rdy_mode = 2; bhs = hs_total;
        pulse_start(3, s);
        i = 0;
        while (!(hs_total >= bhs + 1 && px_valid_o) && i < 300) begin @(negedge clk); i++; end
        chk("t6_reach_send", {31'd0, hs_total >= bhs + 1 && px_valid_o}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rd_en", {31'd0, rd_en_o}, 32'd0);
        chk("t6_px_valid", {31'd0, px_valid_o}, 32'd0);
        chk("t6_px_data", {8'd0, px_data_o}, 32'd0);
        chk("t6_busy", {31'd0, busy_o}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rdy_mode = 0; first_rd = -1; bhs = hs_total; base = done_cnt;
        pulse_start(2, s);
        wait_done(base + 1, 100, "t6_timeout");
        chk("t6_restart_addr", first_addr, 32'd0);
        chk("t6_restart_hs", hs_total - bhs, 32'd2);

        // Randomized frames with random ready/idle and occasional queued starts
        rdy_mode = 1; ser_mode = 1;
        for (int it = 0; it < 8; it++) begin
            for (int k = 0; k < NL; k++) ram[k] = 24'($urandom);
            base = done_cnt; ex = 1;
            pulse_start($urandom_range(0, 15), s);
            if ($urandom_range(0, 1) == 1) begin
                pulse_start($urandom_range(0, 15), s);
                ex = 2;
            end
            wait_done(base + ex, 800, "rand_timeout");
        end
        rdy_mode = 0; ser_mode = 0; ser_idle_i = 1'b1;
        repeat (5) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
